// File: rtl/buf_alloc_pkg.sv
// Shared definitions for the parametrised buffer allocator.
// Contents:
//   BUF_ALLOC_DEF_DEPTH  default number of buffer slots
//   clog2_min1()         ceil(log2(n)) clamped to at least 1, for widths
//   popcount()           number of set bits in a vector of up to 256 bits
package buf_alloc_pkg;

  localparam int unsigned BUF_ALLOC_DEF_DEPTH = 16;

  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned r;
    r = 1;
    while ((r < 32) && ((32'd1 << r) < n)) begin
      r = r + 1;
    end
    return r;
  endfunction

  function automatic int unsigned popcount(input logic [255:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < 256; i++) begin
      c = c + int'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/buf_alloc_param_if.sv
// Request/response bundle between the request front-end and the allocator.
// Master (front-end) drives:
//   alloc_raw, free_raw, free_addr_raw
// Slave (allocator) drives:
//   nack, alloc_grant, alloc_addr, count, full, empty, busy_vec,
//   err_free_idle, err_free_range
//   almost_full (only when BUF_ALLOC_ALMOST_FULL_EN is defined)
interface buf_alloc_param_if
  import buf_alloc_pkg::*;
#(
  parameter int unsigned DEPTH  = BUF_ALLOC_DEF_DEPTH,
  parameter int unsigned ADDR_W = clog2_min1(DEPTH),
  parameter int unsigned CNT_W  = clog2_min1(DEPTH + 1)
);

  logic              alloc_raw;
  logic              free_raw;
  logic [ADDR_W-1:0] free_addr_raw;
  logic              nack;
  logic              alloc_grant;
  logic [ADDR_W-1:0] alloc_addr;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;
  logic [DEPTH-1:0]  busy_vec;
  logic              err_free_idle;
  logic              err_free_range;
`ifdef BUF_ALLOC_ALMOST_FULL_EN
  logic              almost_full;
`endif

  modport master (
    output alloc_raw, free_raw, free_addr_raw,
    input  nack, alloc_grant, alloc_addr, count, full, empty, busy_vec,
           err_free_idle, err_free_range
`ifdef BUF_ALLOC_ALMOST_FULL_EN
    , input almost_full
`endif
  );

  modport slave (
    input  alloc_raw, free_raw, free_addr_raw,
    output nack, alloc_grant, alloc_addr, count, full, empty, busy_vec,
           err_free_idle, err_free_range
`ifdef BUF_ALLOC_ALMOST_FULL_EN
    , output almost_full
`endif
  );

endinterface

// File: rtl/buf_alloc_first_free.sv
// Lowest-zero finder over the busy bitmap.
// Ports:
//   busy_vec   input  DEPTH   busy bitmap, bit i is slot i
//   addr       output ADDR_W  lowest index with busy_vec[i] == 0, 0 when none
//   none_free  output 1       every slot is busy
module buf_alloc_first_free
  import buf_alloc_pkg::*;
#(
  parameter int unsigned DEPTH  = BUF_ALLOC_DEF_DEPTH,
  parameter int unsigned ADDR_W = clog2_min1(DEPTH)
) (
  input  logic [DEPTH-1:0]  busy_vec,
  output logic [ADDR_W-1:0] addr,
  output logic              none_free
);

  // Scan from the top down so the last hit (lowest index) wins.
  always_comb begin
    addr = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy_vec[i]) begin
        addr = ADDR_W'(i);
      end
    end
  end

  assign none_free = &busy_vec;

endmodule

// File: rtl/buf_alloc_param.sv
// Parametrised buffer slot allocator.
// Registers alloc/free requests, answers an allocation one cycle later with
// either a grant of the lowest free slot or a nack when the pool is full, and
// commits bitmap/count updates on the following edge. Illegal frees leave the
// pool untouched and raise sticky error flags.
// Ports:
//   clock    sole clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      buf_alloc_param_if.slave (request inputs, status outputs)
// Optional feature macro: BUF_ALLOC_ALMOST_FULL_EN adds the registered
// almost_full output (count_next >= AF_THRESH) and the AF_THRESH parameter.
module buf_alloc_param
  import buf_alloc_pkg::*;
#(
  parameter int unsigned DEPTH  = BUF_ALLOC_DEF_DEPTH,
  parameter int unsigned ADDR_W = clog2_min1(DEPTH),
  parameter int unsigned CNT_W  = clog2_min1(DEPTH + 1)
`ifdef BUF_ALLOC_ALMOST_FULL_EN
  , parameter int unsigned AF_THRESH = DEPTH - 2
`endif
) (
  input logic              clock,
  input logic              reset_n,
  buf_alloc_param_if.slave bus
);

  logic              r_alloc_q;
  logic              r_free_q;
  logic [ADDR_W-1:0] r_free_addr_q;
  logic [DEPTH-1:0]  r_busy_vec;
  logic [CNT_W-1:0]  r_count;
  logic              r_err_free_idle;
  logic              r_err_free_range;

  logic              w_full;
  logic              w_empty;
  logic              w_grant;
  logic              w_nack;
  logic              w_none_free;
  logic [ADDR_W-1:0] w_alloc_addr;
  logic [DEPTH-1:0]  w_free_onehot;
  logic [DEPTH-1:0]  w_alloc_onehot;
  logic [DEPTH-1:0]  w_busy_d;
  logic              w_free_in_range;
  logic              w_free_hit;
  logic              w_free_ok;
  logic              w_free_idle;
  logic [CNT_W-1:0]  w_count_d;

  buf_alloc_first_free #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_first_free (
    .busy_vec  (r_busy_vec),
    .addr      (w_alloc_addr),
    .none_free (w_none_free)
  );

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_grant = r_alloc_q & ~w_full;
  assign w_nack  = r_alloc_q & w_full;

  // Decode the free address against real slots only, so an out-of-range
  // address can never alias onto a slot.
  assign w_free_in_range = (32'(r_free_addr_q) < DEPTH);

  always_comb begin
    w_free_onehot  = '0;
    w_alloc_onehot = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_free_onehot[i]  = (r_free_addr_q == ADDR_W'(i));
      w_alloc_onehot[i] = w_grant && (w_alloc_addr == ADDR_W'(i));
    end
  end

  assign w_free_hit  = |(w_free_onehot & r_busy_vec);
  assign w_free_ok   = r_free_q & w_free_in_range & w_free_hit;
  assign w_free_idle = r_free_q & w_free_in_range & ~w_free_hit;

  // Grant address comes from the pre-free bitmap, so the freed slot and the
  // granted slot are always distinct.
  assign w_busy_d  = (r_busy_vec & ~(w_free_ok ? w_free_onehot : '0)) | w_alloc_onehot;
  assign w_count_d = r_count + CNT_W'(w_grant) - CNT_W'(w_free_ok);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_alloc_q        <= 1'b0;
      r_free_q         <= 1'b0;
      r_free_addr_q    <= '0;
      r_busy_vec       <= '0;
      r_count          <= '0;
      r_err_free_idle  <= 1'b0;
      r_err_free_range <= 1'b0;
    end else begin
      r_alloc_q     <= bus.alloc_raw;
      r_free_q      <= bus.free_raw;
      r_free_addr_q <= bus.free_addr_raw;
      r_busy_vec    <= w_busy_d;
      r_count       <= w_count_d;
      if (w_free_idle) begin
        r_err_free_idle <= 1'b1;
      end
      if (r_free_q && !w_free_in_range) begin
        r_err_free_range <= 1'b1;
      end
    end
  end

`ifdef BUF_ALLOC_ALMOST_FULL_EN
  logic r_almost_full;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_almost_full <= 1'b0;
    end else begin
      r_almost_full <= (32'(w_count_d) >= AF_THRESH);
    end
  end

  assign bus.almost_full = r_almost_full;
`endif

  assign bus.nack           = w_nack;
  assign bus.alloc_grant    = w_grant;
  assign bus.alloc_addr     = w_alloc_addr;
  assign bus.count          = r_count;
  assign bus.full           = w_full;
  assign bus.empty          = w_empty;
  assign bus.busy_vec       = r_busy_vec;
  assign bus.err_free_idle  = r_err_free_idle;
  assign bus.err_free_range = r_err_free_range;

  a_count_popcount: assert property (@(posedge clock) disable iff (!reset_n)
    r_count == CNT_W'(popcount(256'(r_busy_vec))));
  a_full_not_empty: assert property (@(posedge clock) disable iff (!reset_n)
    !(w_full && w_empty));
  a_full_consistent: assert property (@(posedge clock) disable iff (!reset_n)
    w_none_free == w_full);

endmodule

// File: doc/buf_alloc_param.md
Name: buf_alloc_param

Overview:
Parametrised successor to the 16-entry buffer allocator. Tracks DEPTH buffer slots with a busy bitmap and a live count. Hands out the lowest-numbered free slot on request and releases slots on free. Adds a full/empty indication, a busy-vector export and error flags for illegal frees; sits between the request front-end and the buffer RAM address path.

Parameters:
DEPTH, 16, number of buffer slots; legal range 2..256, need not be a power of two.
ADDR_W, $clog2(DEPTH), slot address width.
CNT_W, $clog2(DEPTH+1), occupancy count width.
AF_THRESH, DEPTH-2, almost-full threshold; used only with the optional feature.

Ports:
clock  input  1  sole clock, rising edge.
reset_n  input  1  asynchronous, active-low reset.
alloc_raw  input  1  allocation request.
free_raw  input  1  free request.
free_addr_raw  input  ADDR_W  slot to free.
nack  output  1  registered request refused because the pool is full.
alloc_grant  output  1  registered request accepted this cycle.
alloc_addr  output  ADDR_W  lowest free slot.
count  output  CNT_W  number of busy slots.
full  output  1  count == DEPTH.
empty  output  1  count == 0.
busy_vec  output  DEPTH  busy bitmap; bit i is slot i.
err_free_idle  output  1  sticky: a free targeted a slot that was not busy.
err_free_range  output  1  sticky: free_addr >= DEPTH.

Behaviour:
- Reset (async assert, sync release): busy_vec=0, count=0, alloc_q=free_q=0, free_addr_q=0, both error flags 0.
- Resulting reset values: nack=0, alloc_grant=0, alloc_addr=0, full=0, empty=1.
- Input stage: at edge E, alloc_raw, free_raw and free_addr_raw are registered into alloc_q, free_q and free_addr_q.
- Request latency: one cycle from the raw input to the response.
- nack = alloc_q & full.
- alloc_grant = alloc_q & ~full.
- alloc_addr = lowest index i with busy_vec[i]=0, or 0 when full. It is combinational from the current busy_vec and is valid whenever alloc_grant is high.
- Update at the edge following the response cycle:
  - free_ok = free_q & (free_addr_q < DEPTH) & busy_vec[free_addr_q].
  - count_next = count + alloc_grant - free_ok.
  - If free_ok: clear busy_vec[free_addr_q].
  - If alloc_grant: set busy_vec[alloc_addr].
- Simultaneous free and alloc: alloc_addr is taken from the pre-free bitmap, so a slot freed this cycle is not reallocated in the same cycle.
  - When full, nack still asserts even with a concurrent valid free; count goes DEPTH to DEPTH-1.
  - A free of slot X and a grant of slot Y never collide: Y was free and X was busy.
- Illegal frees:
  - free_q on a slot that is not busy: no state change; err_free_idle is set.
  - free_addr_q >= DEPTH: ignored; err_free_range is set.
  - Both flags clear only on reset.
- Arithmetic: count never wraps; it stays within 0..DEPTH.
- Invariants: count == popcount(busy_vec); full and empty are never both 1.
- Reset mid-operation: all state clears immediately, and requests that are in flight are dropped.

Optional Feature:
Macro: BUF_ALLOC_ALMOST_FULL_EN.
- Defined: adds output almost_full (1 bit). It is registered and equals (count_next >= AF_THRESH), so it is aligned with count. Reset value is 0.
- Not defined: the port and its logic are absent; the interface is exactly as listed above.

Decomposition:
- Package buf_alloc_pkg:
  - localparam BUF_ALLOC_DEF_DEPTH = 16.
  - Function clog2_min1, which returns at least 1.
  - Function popcount, used by the bench and assertions.
- Sub-module buf_alloc_first_free: parametrised lowest-zero finder.
  - Input busy_vec[DEPTH].
  - Outputs addr[ADDR_W] and none_free.
  - Implemented as a loop or tree priority encoder.
- The top module holds the input registers, bitmap, counter and error logic.

Test Plan:
- DEPTH=16, reset, alloc_raw=1 for 17 cycles -> grants at addresses 0..15, count reaches 16, full=1; 17th request gives nack=1, alloc_grant=0, count stays 16.
- After fill, free slot 5, then alloc next cycle -> alloc_addr=5, count 15->16, busy_vec=16'hFFFF.
- Full pool, same cycle alloc + free slot 3 -> nack=1, count=15, busy_vec[3]=0; next alloc -> alloc_addr=3.
- Empty pool, free slot 7 -> count=0 unchanged, err_free_idle=1 and stays 1 through later valid traffic until reset_n=0.
- DEPTH=12, free_addr_raw=13 with free_raw=1 -> err_free_range=1, busy_vec unchanged; fill gives 12 grants, then nack.
- reset_n pulsed low mid-burst between clock edges -> outputs clear asynchronously (count=0, empty=1); first request after release returns addr 0.
